// File: rtl/intctl_pkg.sv
// Shared constants for the wb_intctl interrupt controller: register word addresses,
// CTRL field positions and the priority width.
package intctl_pkg;

   localparam int unsigned PrioW = 3;

   // Word addresses (wb_adr_i[4:1]) inside the 0xFF20 I/O window.
   typedef enum logic [3:0] {
      AdrEoi     = 4'h1,
      AdrPoll    = 4'h2,
      AdrPollSts = 4'h3,
      AdrMask    = 4'h4,
      AdrPriMsk  = 4'h5,
      AdrInServ  = 4'h6,
      AdrReqSt   = 4'h7,
      AdrCtrl0   = 4'h8
   } reg_adr_e;

   localparam int unsigned CtrlPrioLsb = 0;
   localparam int unsigned CtrlMaskBit = 3;
   localparam int unsigned CtrlLvlBit  = 4;
   localparam int unsigned EoiNspec    = 15;

endpackage

// File: rtl/intctl_arb.sv
// Combinational winner select: lowest priority value among unmasked requests that clear
// both the PRIMSK threshold and every in-service priority; ties go to the lowest index.
module intctl_arb
   import intctl_pkg::*;
#(
   parameter int unsigned N_IRQ = 4
) (
   input  logic [N_IRQ-1:0]       i_req,
   input  logic [N_IRQ-1:0]       i_mask,
   input  logic [N_IRQ-1:0]       i_isr,
   input  logic [N_IRQ*PrioW-1:0] i_prio,
   input  logic [PrioW-1:0]       i_primsk,
   output logic [2:0]             o_idx,
   output logic                   o_valid
);

   logic [PrioW:0]   w_ceil;
   logic [PrioW-1:0] w_best;
   logic [PrioW-1:0] w_p;

   always_comb begin
      // Ceiling is one above the largest priority when nothing is in service.
      w_ceil = {1'b1, {PrioW{1'b0}}};
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         if (i_isr[k] && ({1'b0, i_prio[k*PrioW +: PrioW]} < w_ceil)) begin
            w_ceil = {1'b0, i_prio[k*PrioW +: PrioW]};
         end
      end
      o_valid = 1'b0;
      o_idx   = 3'd0;
      w_best  = '1;
      w_p     = '0;
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         w_p = i_prio[k*PrioW +: PrioW];
         if (i_req[k] && !i_mask[k] && (w_p <= i_primsk) && ({1'b0, w_p} < w_ceil) &&
             (!o_valid || (w_p < w_best))) begin
            o_valid = 1'b1;
            o_idx   = 3'(k);
            w_best  = w_p;
         end
      end
   end

endmodule

// File: rtl/wb_intctl.sv
// Wishbone-slave interrupt controller driving the Zet intr/inta handshake.
// Define INTCTL_POLL_EN to enable the POLL (software acknowledge) and POLLSTS registers.
module wb_intctl
   import intctl_pkg::*;
#(
   parameter int unsigned N_IRQ    = 4,
   parameter logic [7:0]  VEC_BASE = 8'h0C,
   parameter logic [7:0]  SPUR_VEC = 8'h0F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      wb_dat_i,
   output logic [15:0]      wb_dat_o,
   input  logic [3:0]       wb_adr_i,
   input  logic             wb_we_i,
   input  logic [1:0]       wb_sel_i,
   input  logic             wb_stb_i,
   input  logic             wb_cyc_i,
   output logic             wb_ack_o,
   input  logic [N_IRQ-1:0] irq_i,
   output logic             intr,
   input  logic             inta,
   output logic [7:0]       vec
);

   logic [N_IRQ-1:0]       r_s1, r_s2, r_s3;
   logic [N_IRQ-1:0]       r_req, r_isr, r_mask, r_lvl;
   logic [N_IRQ*PrioW-1:0] r_prio;
   logic [PrioW-1:0]       r_primsk;
   logic                   r_inta_q, r_intr, r_ack;
   logic [7:0]             r_vec;
   logic [15:0]            r_dat;

   logic                   w_acc, w_wr, w_rd, w_inta_edge, w_poll_rd, w_latch;
   logic [2:0]             w_win_idx, w_ns_idx;
   logic                   w_win_valid, w_ns_valid;
   logic [7:0]             w_win_vec, w_eoi_idx;
   logic [N_IRQ-1:0]       w_rise, w_req_d, w_isr_d;
   logic [15:0]            w_rdat;
   logic                   w_unused;

   assign w_acc       = wb_stb_i & wb_cyc_i & ~r_ack;
   assign w_wr        = w_acc & wb_we_i;
   assign w_rd        = w_acc & ~wb_we_i;
   assign w_inta_edge = inta & ~r_inta_q;
   assign w_rise      = r_s2 & ~r_s3;
   assign w_win_vec   = VEC_BASE + {5'b0, w_win_idx};
   assign w_eoi_idx   = wb_dat_i[7:0] - VEC_BASE;
   assign w_unused    = ^wb_dat_i[14:8];

`ifdef INTCTL_POLL_EN
   logic [15:0] w_poll_dat;
   assign w_poll_rd  = w_rd & (wb_adr_i == AdrPoll);
   assign w_poll_dat = w_win_valid ? {1'b1, 7'b0, w_win_vec} : 16'h0000;
`else
   assign w_poll_rd  = 1'b0;
`endif

   // A POLL read and an inta edge in the same cycle collapse into one acknowledge.
   assign w_latch = (w_inta_edge | w_poll_rd) & w_win_valid;

   intctl_arb #(
      .N_IRQ    (N_IRQ)
   ) u_arb_win (
      .i_req    (r_req),
      .i_mask   (r_mask),
      .i_isr    (r_isr),
      .i_prio   (r_prio),
      .i_primsk (r_primsk),
      .o_idx    (w_win_idx),
      .o_valid  (w_win_valid)
   );

   // Non-specific EOI: highest-priority in-service channel, no other qualification.
   intctl_arb #(
      .N_IRQ    (N_IRQ)
   ) u_arb_eoi (
      .i_req    (r_isr),
      .i_mask   ('0),
      .i_isr    ('0),
      .i_prio   (r_prio),
      .i_primsk ('1),
      .o_idx    (w_ns_idx),
      .o_valid  (w_ns_valid)
   );

   always_comb begin
      w_isr_d = r_isr;
      if (w_wr && (wb_adr_i == AdrEoi)) begin
         for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (wb_sel_i[1] && wb_dat_i[EoiNspec]) begin
               if (w_ns_valid && (w_ns_idx == 3'(k))) w_isr_d[k] = 1'b0;
            end else if (wb_sel_i[0] && (w_eoi_idx == 8'(k))) begin
               w_isr_d[k] = 1'b0;
            end
         end
      end
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         if (w_latch && (w_win_idx == 3'(k))) w_isr_d[k] = 1'b1;
         if (r_lvl[k]) begin
            w_req_d[k] = r_s2[k];
         end else begin
            w_req_d[k] = (r_req[k] & ~(w_latch & (w_win_idx == 3'(k)))) | w_rise[k];
         end
      end
   end

   always_comb begin
      w_rdat = 16'h0000;
      case (wb_adr_i)
`ifdef INTCTL_POLL_EN
         AdrPoll, AdrPollSts: w_rdat = w_poll_dat;
`endif
         AdrMask:   w_rdat[N_IRQ-1:0] = r_mask;
         AdrPriMsk: w_rdat[PrioW-1:0] = r_primsk;
         AdrInServ: w_rdat[N_IRQ-1:0] = r_isr;
         AdrReqSt:  w_rdat[N_IRQ-1:0] = r_req;
         default: begin
            for (int unsigned k = 0; k < N_IRQ; k++) begin
               if (wb_adr_i[3] && (wb_adr_i[2:0] == 3'(k))) begin
                  w_rdat[CtrlPrioLsb +: PrioW] = r_prio[k*PrioW +: PrioW];
                  w_rdat[CtrlMaskBit]          = r_mask[k];
                  w_rdat[CtrlLvlBit]           = r_lvl[k];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_s3     <= '0;
         r_req    <= '0;
         r_isr    <= '0;
         r_mask   <= '1;
         r_lvl    <= '0;
         r_prio   <= '1;
         r_primsk <= '1;
         r_inta_q <= 1'b0;
         r_intr   <= 1'b0;
         r_ack    <= 1'b0;
         r_vec    <= 8'h00;
         r_dat    <= 16'h0000;
      end else begin
         r_s1     <= irq_i;
         r_s2     <= r_s1;
         r_s3     <= r_s2;
         r_req    <= w_req_d;
         r_isr    <= w_isr_d;
         r_inta_q <= inta;
         r_intr   <= w_win_valid;
         r_ack    <= w_acc;
         r_dat    <= w_rd ? w_rdat : 16'h0000;
         if (w_inta_edge) r_vec <= w_win_valid ? w_win_vec : SPUR_VEC;
         if (w_wr && wb_sel_i[0]) begin
            if (wb_adr_i == AdrMask)   r_mask   <= wb_dat_i[N_IRQ-1:0];
            if (wb_adr_i == AdrPriMsk) r_primsk <= wb_dat_i[PrioW-1:0];
            for (int unsigned k = 0; k < N_IRQ; k++) begin
               if (wb_adr_i[3] && (wb_adr_i[2:0] == 3'(k))) begin
                  r_prio[k*PrioW +: PrioW] <= wb_dat_i[CtrlPrioLsb +: PrioW];
                  r_mask[k]                <= wb_dat_i[CtrlMaskBit];
                  r_lvl[k]                 <= wb_dat_i[CtrlLvlBit];
               end
            end
         end
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;
   assign intr     = r_intr;
   assign vec      = r_vec;

endmodule

// File: tb/tb_wb_intctl.sv
// Directed bench for wb_intctl: a rule-level model checked every cycle plus literal checks.
module tb_wb_intctl;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] wb_dat_i = '0;
   logic [15:0] wb_dat_o;
   logic [3:0]  wb_adr_i = '0;
   logic        wb_we_i = 1'b0;
   logic [1:0]  wb_sel_i = 2'b11;
   logic        wb_stb_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_ack_o;
   logic [N-1:0] irq_i = '0;
   logic        intr;
   logic        inta = 1'b0;
   logic [7:0]  vec;

   int n_tests = 0;
   int n_fail  = 0;

   wb_intctl #(
      .N_IRQ    (N),
      .VEC_BASE (8'h0C),
      .SPUR_VEC (8'h0F)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_adr_i (wb_adr_i),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_ack_o (wb_ack_o),
      .irq_i    (irq_i),
      .intr     (intr),
      .inta     (inta),
      .vec      (vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: state as the rules describe it ----------------
   logic [N-1:0] m_req, m_isr, m_mask, m_lvl, m_p1, m_p2, m_p3;
   int           m_prio [N];
   int           m_primsk;
   logic [7:0]   m_vec;
   logic         m_intr, m_ack, m_rd_valid, m_inta_q;
   logic [15:0]  m_rdat;

   function automatic bit below_isr(input int p);
      for (int j = 0; j < N; j++) if (m_isr[j] && m_prio[j] <= p) return 1'b0;
      return 1'b1;
   endfunction

   // Scan priority levels best-first, indices low-first; -1 when nothing qualifies.
   function automatic int pick();
      for (int p = 0; p < 8; p++)
         for (int k = 0; k < N; k++)
            if (m_prio[k] == p && m_req[k] && !m_mask[k] && p <= m_primsk && below_isr(p))
               return k;
      return -1;
   endfunction

   function automatic int top_isr();
      for (int p = 0; p < 8; p++)
         for (int k = 0; k < N; k++)
            if (m_isr[k] && m_prio[k] == p) return k;
      return -1;
   endfunction

   function automatic logic [15:0] reg_read(input int adr, input int w);
      logic [15:0] d;
      d = '0;
      case (adr)
`ifdef INTCTL_POLL_EN
         2, 3: d = (w >= 0) ? (16'h8000 | 16'(12 + w)) : 16'h0000;
`endif
         4: d = 16'(m_mask);
         5: d = 16'(m_primsk);
         6: d = 16'(m_isr);
         7: d = 16'(m_req);
         default:
            if (adr >= 8 && adr < 8 + N)
               d = 16'(m_prio[adr-8]) | (m_mask[adr-8] ? 16'h0008 : 16'h0000) |
                   (m_lvl[adr-8] ? 16'h0010 : 16'h0000);
      endcase
      return d;
   endfunction

   task automatic model_reset();
      m_req = '0; m_isr = '0; m_mask = '1; m_lvl = '0;
      m_p1 = '0; m_p2 = '0; m_p3 = '0;
      for (int k = 0; k < N; k++) m_prio[k] = 7;
      m_primsk = 7; m_vec = 8'h00; m_intr = 1'b0; m_ack = 1'b0;
      m_rd_valid = 1'b0; m_inta_q = 1'b0; m_rdat = '0;
   endtask

   task automatic model_step();
      int w, adr, j, t;
      logic acc, wr, rd, edge_a, poll, latch;
      logic [N-1:0] nreq;
      adr    = int'(wb_adr_i);
      acc    = wb_stb_i & wb_cyc_i & !m_ack;
      wr     = acc & wb_we_i;
      rd     = acc & !wb_we_i;
      edge_a = inta & !m_inta_q;
      w      = pick();
      poll   = 1'b0;
`ifdef INTCTL_POLL_EN
      poll   = rd && adr == 2;
`endif
      m_rdat     = rd ? reg_read(adr, w) : 16'h0000;
      m_rd_valid = rd;
      latch      = (edge_a || poll) && w >= 0;
      if (wr && adr == 1) begin
         if (wb_sel_i[1] && wb_dat_i[15]) begin
            j = top_isr();
            if (j >= 0) m_isr[j] = 1'b0;
         end else if (wb_sel_i[0]) begin
            t = int'(wb_dat_i[7:0]) - 12;
            if (t >= 0 && t < N) m_isr[t] = 1'b0;
         end
      end
      if (latch) m_isr[w] = 1'b1;
      if (edge_a) m_vec = (w >= 0) ? 8'(12 + w) : 8'h0F;
      for (int k = 0; k < N; k++)
         nreq[k] = m_lvl[k] ? m_p2[k]
                            : ((m_req[k] && !(latch && w == k)) || (m_p2[k] && !m_p3[k]));
      m_req = nreq;
      if (wr && wb_sel_i[0]) begin
         if (adr == 4) m_mask = wb_dat_i[N-1:0];
         if (adr == 5) m_primsk = int'(wb_dat_i[2:0]);
         if (adr >= 8 && adr < 8 + N) begin
            m_prio[adr-8] = int'(wb_dat_i[2:0]);
            m_mask[adr-8] = wb_dat_i[3];
            m_lvl[adr-8]  = wb_dat_i[4];
         end
      end
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = irq_i;
      m_intr = (w >= 0); m_ack = acc; m_inta_q = inta;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (rst) model_reset();
         else model_step();
         #1;
         chk("ack", {15'b0, wb_ack_o}, {15'b0, m_ack});
         chk("intr", {15'b0, intr}, {15'b0, m_intr});
         chk("vec", {8'b0, vec}, {8'b0, m_vec});
         if (m_ack && m_rd_valid) chk("rdata", wb_dat_o, m_rdat);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic xfer(input logic we, input logic [3:0] adr, input logic [15:0] dat,
                       input logic [1:0] sel, output logic [15:0] rdat);
      logic got;
      got = 1'b0;
      rdat = '0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin got = 1'b1; rdat = wb_dat_o; end
      end
      chk("wb_ack_seen", {15'b0, got}, 16'h0001);
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wr(input logic [3:0] adr, input logic [15:0] dat);
      logic [15:0] d;
      xfer(1'b1, adr, dat, 2'b11, d);
   endtask

   task automatic rd(input string name, input logic [3:0] adr, input logic [15:0] exp);
      logic [15:0] d;
      xfer(1'b0, adr, 16'h0000, 2'b11, d);
      chk(name, d, exp);
   endtask

   task automatic pulse(input int k);
      @(negedge clk); irq_i[k] = 1'b1;
      @(negedge clk); irq_i[k] = 1'b0;
   endtask

   task automatic wait_intr(input string name, input int budget);
      logic got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(posedge clk); #1;
         if (intr) got = 1'b1;
      end
      chk(name, {15'b0, got}, 16'h0001);
   endtask

   task automatic do_inta(input string name, input logic [7:0] exp);
      @(negedge clk); inta = 1'b1;
      @(posedge clk); #1;
      chk(name, {8'b0, vec}, {8'b0, exp});
      @(negedge clk); inta = 1'b0;
   endtask

   task automatic chk_intr_now(input string name, input logic exp);
      @(posedge clk); #1;
      chk(name, {15'b0, intr}, {15'b0, exp});
   endtask

   logic c1, c2, c3, c4;
   logic [15:0] dd;

   initial begin
      #1;
      chk("rst_intr", {15'b0, intr}, 16'h0000);
      chk("rst_vec", {8'b0, vec}, 16'h0000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rd("rst_mask", 4'h4, 16'h000F);
      rd("rst_primsk", 4'h5, 16'h0007);
      rd("rst_ctrl0", 4'h8, 16'h000F);
      rd("rst_inserv", 4'h6, 16'h0000);

      // 1: edge source latency and acknowledge
      wr(4'h8, 16'h0000);
      @(negedge clk); irq_i[0] = 1'b1;
      @(posedge clk); #1; c1 = intr;
      @(negedge clk); irq_i[0] = 1'b0;
      @(posedge clk); #1; c2 = intr;
      @(posedge clk); #1; c3 = intr;
      @(posedge clk); #1; c4 = intr;
      chk("lat_edges123", {13'b0, c1, c2, c3}, 16'h0000);
      chk("lat_edge4", {15'b0, c4}, 16'h0001);
      do_inta("t1_vec", 8'h0C);
      chk_intr_now("t1_intr_drop", 1'b0);
      rd("t1_inserv", 4'h6, 16'h0001);
      rd("t1_reqst", 4'h7, 16'h0000);
      wr(4'h1, 16'h000C);
      rd("t1_eoi", 4'h6, 16'h0000);

      // 2: nesting
      wr(4'h9, 16'h0005);
      wr(4'h8, 16'h0002);
      pulse(1);
      wait_intr("t2_intr1", 8);
      do_inta("t2_vec1", 8'h0D);
      pulse(0);
      wait_intr("t2_intr0", 8);
      do_inta("t2_vec0", 8'h0C);
      rd("t2_inserv", 4'h6, 16'h0003);

      // 3: non-specific EOI
      wr(4'h1, 16'h8000);
      rd("t3_ns1", 4'h6, 16'h0002);
      wr(4'h1, 16'h8000);
      rd("t3_ns2", 4'h6, 16'h0000);

      // 2b: in-service ch0 blocks lower-priority ch1 until specific EOI
      pulse(0);
      wait_intr("t2b_intr0", 8);
      do_inta("t2b_vec0", 8'h0C);
      pulse(1);
      repeat (8) @(posedge clk);
      #1 chk("t2b_blocked", {15'b0, intr}, 16'h0000);
      wr(4'h1, 16'h000C);
      wait_intr("t2b_unblock", 4);
      do_inta("t2b_vec1", 8'h0D);
      wr(4'h1, 16'h000D);
      rd("t2b_inserv", 4'h6, 16'h0000);

      // 4: level mode
      wr(4'hA, 16'h0010);
      @(negedge clk); irq_i[2] = 1'b1;
      wait_intr("t4_intr", 8);
      do_inta("t4_vec", 8'h0E);
      repeat (3) @(posedge clk);
      #1 chk("t4_blocked", {15'b0, intr}, 16'h0000);
      rd("t4_reqst", 4'h7, 16'h0004);
      wr(4'h1, 16'h000E);
      wait_intr("t4_reassert", 4);
      @(negedge clk); irq_i[2] = 1'b0;
      repeat (3) @(posedge clk);
      rd("t4_reqst_clr", 4'h7, 16'h0000);
      #1 chk("t4_no_intr", {15'b0, intr}, 16'h0000);
      wr(4'hA, 16'h0008);

      // 5: PRIMSK threshold, mask vs latch, spurious
      wr(4'h5, 16'h0003);
      wr(4'h8, 16'h0004);
      pulse(0);
      repeat (8) @(posedge clk);
      #1 chk("t5_primsk_block", {15'b0, intr}, 16'h0000);
      wr(4'h5, 16'h0004);
      chk_intr_now("t5_primsk_open", 1'b1);
      do_inta("t5_vec", 8'h0C);
      wr(4'h1, 16'h000C);
      pulse(0);
      wait_intr("t5_pend", 8);
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 4'h4; wb_dat_i = 16'h000F; wb_sel_i = 2'b11; inta = 1'b1;
      @(posedge clk); #1;
      chk("mask_vs_ack", {8'b0, vec}, 16'h000C);
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; inta = 1'b0;
      rd("t5_inserv", 4'h6, 16'h0001);
      wr(4'h1, 16'h000C);
      rd("t5_ctrl0_alias", 4'h8, 16'h000C);
      pulse(0);
      repeat (6) @(posedge clk);
      #1 chk("t5_masked", {15'b0, intr}, 16'h0000);
      do_inta("t5_spur", 8'h0F);
      rd("t5_spur_inserv", 4'h6, 16'h0000);
      xfer(1'b1, 4'h5, 16'h0000, 2'b10, dd);
      rd("byte_lane", 4'h5, 16'h0004);
      rd("unmap_0", 4'h0, 16'h0000);
      rd("unmap_ctrl4", 4'hC, 16'h0000);
      rd("eoi_rd", 4'h1, 16'h0000);

`ifdef INTCTL_POLL_EN
      // 6: software acknowledge
      wr(4'h5, 16'h0007);
      wr(4'hB, 16'h0001);
      pulse(3);
      wait_intr("t6_intr", 8);
      rd("t6_pollsts", 4'h3, 16'h800F);
      rd("t6_inserv0", 4'h6, 16'h0000);
      rd("t6_poll", 4'h2, 16'h800F);
      rd("t6_inserv1", 4'h6, 16'h0008);
      rd("t6_poll2", 4'h2, 16'h0000);
`else
      rd("poll_off", 4'h2, 16'h0000);
      rd("pollsts_off", 4'h3, 16'h0000);
`endif

      // Reset in the middle of a bus cycle and handshake
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h6; inta = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ack", {15'b0, wb_ack_o}, 16'h0000);
      chk("mid_rst_vec", {8'b0, vec}, 16'h0000);
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; inta = 1'b0;
      @(negedge clk); rst = 1'b0;
      rd("post_rst_mask", 4'h4, 16'h000F);
      rd("post_rst_inserv", 4'h6, 16'h0000);

      repeat (2) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_intctl.md
Name: wb_intctl

Overview:
- Parametrised Wishbone-slave interrupt controller for the Zet/80186 co-processor SoC.
- Replaces the fixed simple_pic and the stubbed Interrupt Control slave in the 0xFF20–0xFF3E I/O window.
- Provides N_IRQ sources with per-channel priority, mask, edge/level mode, in-service nesting, EOI and a priority-mask threshold.
- Drives the Zet intr/inta handshake and supplies the 8-bit interrupt type.

Parameters:
- N_IRQ, 4, number of sources; range 1..8.
- VEC_BASE, 8'h0C, type number of channel 0; channel k returns VEC_BASE+k.
- SPUR_VEC, 8'h0F, type returned on an acknowledge when no source is eligible.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_adr_i  in  4  word address [4:1] within the 0xFF20 window.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  2  byte lanes.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- irq_i  in  N_IRQ  asynchronous interrupt sources, active-high.
- intr  out  1  interrupt request to the CPU.
- inta  in  1  CPU acknowledge.
- vec  out  8  interrupt type; valid while inta is high.

Behaviour:
- Reset: all outputs 0; request and ISR registers 0; all masks 1; all priorities 7; all channels edge mode; PRIMSK 7.
- Wishbone: wb_ack_o is registered, pulses 1 cycle after stb&cyc&!ack, so back-to-back accesses take 2 cycles each. Writes honour wb_sel_i byte lanes. Unmapped reads return 0; unmapped writes are ignored.
- Register map (byte offsets):
  - 0x22 EOI (write only). Bit15=1: non-specific, clears the ISR bit of the highest-priority in-service channel. Bit15=0: bits[7:0]=type, clears ISR[type-VEC_BASE] if that index is < N_IRQ, otherwise no effect.
  - 0x28 MASK: bits[N_IRQ-1:0] are an alias of the per-channel mask bits.
  - 0x2A PRIMSK: bits[2:0] priority threshold.
  - 0x2C INSERV: read-only ISR.
  - 0x2E REQST: read-only pending requests.
  - 0x30+2k CTRLk (k<N_IRQ): [2:0] priority (0 highest), [3] mask, [4] level mode.
- Input path: 2-flop synchroniser per irq_i, then an edge-detect flop.
  - Edge mode: a synchronised rising edge sets req[k]. Acknowledge clears it; a new edge in the same cycle as the clear wins.
  - Level mode: req[k] equals the synchronised level.
- Eligibility: req[k], !mask[k], prio[k] <= PRIMSK, and prio[k] strictly less than every in-service channel's priority. Ties go to the lowest index.
- intr is registered, equal to "any eligible", recomputed every cycle.
  - Latency: irq_i rise to intr high is 4 clk edges.
  - intr drops on the cycle after the acknowledge latch.
- Acknowledge: on the rising edge of inta (inta & !inta_q), latch the winner, set ISR[w], clear req[w] (edge mode), set vec=VEC_BASE+w.
  - vec holds until the next acknowledge.
  - No eligible source: vec=SPUR_VEC, no state change.
- Simultaneous events:
  - EOI clearing the ISR bit being set in the same cycle: set wins.
  - Mask write in the same cycle as the acknowledge latch: the latch uses the pre-write mask.
  - Acknowledge latch wins over a register write to the same channel's request.
- Reset mid-handshake or mid-bus-cycle: everything clears asynchronously and no ack is issued.

Optional Feature:
- Macro INTCTL_POLL_EN.
- Defined:
  - 0x24 POLL read performs a software acknowledge, identical to the inta edge including ISR set and req clear. Read data: [15]=acknowledge happened, [7:0]=type.
  - 0x26 POLLSTS returns the same format with no side effects.
  - A POLL read and an inta edge in the same cycle are served as one acknowledge; the inta path owns vec.
- Undefined: 0x24 and 0x26 read 0 with no side effect.

Decomposition:
- Package intctl_pkg: register offset constants, CTRL field positions, EOI_NSPEC bit index, priority width (3).
- One sub-module, intctl_arb: combinational winner select (index, valid) from req/mask/prio/ISR/PRIMSK. Shared by the intr logic, the acknowledge logic and the non-specific EOI (with ISR as the request vector).

Test Plan:
1. Reset; write CTRL0=0x0000; pulse irq_i[0] 1 cycle → intr high after 4 edges; raise inta → vec=0x0C, INSERV=0x0001, intr low next cycle, REQST=0x0000.
2. CTRL1=0x0005, CTRL0=0x0002; acknowledge ch1; raise irq0 → intr, vec=0x0C, INSERV=0x0003. Separately, with ch0 in service, irq1 gives no intr until EOI write 0x000C.
3. INSERV=0x0003 (prio 2 and 5); write EOI 0x8000 → INSERV=0x0002; write again → 0x0000.
4. CTRL2=0x0010 (level, prio 0); hold irq2 high, acknowledge, EOI 0x000E → intr reasserts; drop irq2 → REQST bit2 clears within 3 cycles, no intr.
5. PRIMSK=0x0003, CTRL0 prio 4, irq0 → no intr; PRIMSK=0x0004 → intr within 1 cycle. inta with all sources masked → vec=0x0F, INSERV unchanged.
6. INTCTL_POLL_EN defined: pending ch3 → POLLSTS=0x800F with no change; POLL=0x800F then INSERV bit3=1, and a second POLL reads 0x0000.
